img_buffer: RTL and testbench
=============================

IMG_BUFFER -- requirements
Module: img_buffer

Interface
REQ-001 Parameter WIDTH, default 256: image line length in pixels.
REQ-002 Parameter HIGHT, default 256: image height in lines; informational only, no logic depends on it.
REQ-003 Parameter FILT_WIDTH, default 3: window side length; legal values are odd, ≥3, ≤ WIDTH.
REQ-004 Parameter IMGFILE, default "Lena.mem": accepted for instantiation compatibility; SHALL have no functional effect.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 enable  input  1  pixel valid; dataIn is accepted on each rising clk with enable=1.
REQ-008 dataIn  input  8  unsigned pixel, raster order.
REQ-009 FilterBuffer  output  FILT_WIDTH*FILT_WIDTH*8  current window, registered.
REQ-010 FilterFlag  output  1  registered; high when FilterBuffer holds a valid full window.

Function
REQ-011 Define FILL = (FILT_WIDTH-1)*WIDTH + FILT_WIDTH; the block SHALL keep the last FILL accepted pixels.
REQ-012 On each accepted pixel, SHALL shift it in as newest, discard the oldest, and increment an accepted-pixel counter saturating at FILL.
REQ-013 With enable=0: no shift, counter held, window contents held, FilterFlag=0 next cycle (stall, not frame restart).
REQ-014 Window element (r,c), r,c in 0..FILT_WIDTH-1, SHALL equal the pixel accepted (FILT_WIDTH-1-r)*WIDTH + (FILT_WIDTH-1-c) pixels before the newest one.
REQ-015 Element (r,c) SHALL occupy FilterBuffer bits [8k+7:8k], k = r*FILT_WIDTH + c; byte 0 oldest/top-left, top byte newest/bottom-right.
REQ-016 Latency: FilterBuffer and FilterFlag SHALL update on the same edge that accepts the pixel, so they are visible in the cycle after enable=1 is sampled.
REQ-017 FilterFlag SHALL be 1 exactly when that edge accepted a pixel and the counter (after increment) equals FILL; otherwise 0.
REQ-018 No row-edge suppression: windows straddling a line boundary SHALL still be output with FilterFlag=1.
REQ-019 After saturation, the stream SHALL be treated as continuous; successive frames need no reset.
REQ-020 FilterBuffer SHALL change only on accepted pixels or reset.

Reset
REQ-021 rst=0 at a rising clk SHALL clear the counter, FilterFlag to 0 and FilterBuffer to 0; enable is ignored that cycle.
REQ-022 Line-store memory contents need not be cleared; stale data SHALL never be flagged, since the counter restarts at 0.
REQ-023 Reset mid-stream: the first pixel after rst returns high counts as pixel 1, and a new FILL-pixel fill is required.

Structure
REQ-024 A shared package SHALL hold the pixel width constant (8) and a FILL computation function.
REQ-025 One sub-module, img_line_delay (WIDTH-FILT_WIDTH deep, 8-bit, enable-gated delay line), SHALL be instantiated FILT_WIDTH-1 times between rows of FILT_WIDTH-wide window shift registers.

Verification (WIDTH=4, FILT_WIDTH=3, FILL=11, pixel value = index)
REQ-026 Reset, then 10 pixels 0..9 -> FilterFlag stays 0 and FilterBuffer stays 0.
REQ-027 11th pixel (10) -> next cycle FilterFlag=1 and bytes 0..8 = 0,1,2,4,5,6,8,9,10.
REQ-028 12th pixel (11) -> bytes 0..8 = 1,2,3,5,6,7,9,10,11, flag=1 (row-straddle window flagged).
REQ-029 enable low for 3 cycles after pixel 11, then pixel 12 -> flag 0 during the stall with window held; then bytes 0..8 = 2,3,4,6,7,8,10,11,12, flag=1.
REQ-030 rst low for one cycle after pixel 12, then pixels 100..110 -> flag 0 until pixel 110; then bytes 0..8 = 100,101,102,104,105,106,108,109,110.
REQ-031 Stream 40 continuous pixels -> flag=1 on every accepted pixel from the 11th onward; each window satisfies REQ-014.

Source files
------------

// File: rtl/img_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_buffer_pkg
//  Description : Shared pixel type, pixel width and window fill-depth helper
//                for the sliding-window image buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_buffer_pkg;

   // Every pixel in the stream is an 8-bit unsigned value.
   localparam int c_PIX_W = 8;

   typedef logic [c_PIX_W-1:0] pixel_t;

   // Number of accepted pixels needed before the oldest window element
   // (top-left) holds real data: FILT_WIDTH-1 full lines plus one window row.
   function automatic int calc_fill(input int width, input int filt_width);
      return (filt_width - 1) * width + filt_width;
   endfunction

endpackage : img_buffer_pkg
`default_nettype wire

// File: rtl/img_line_delay.sv
`default_nettype none
// ============================================================================
//  Module      : img_line_delay
//  Description : Enable-gated fixed-depth pixel delay line. Carries pixels
//                leaving the left edge of one window row to the right edge of
//                the row above, so the two rows end up one image line apart.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_line_delay
   import img_buffer_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic   clk,
   input  logic   i_en,
   input  pixel_t i_data,
   output pixel_t o_data
);

   generate
      if (DEPTH == 0) begin : g_pass
         // Window as wide as the line: rows abut directly, no storage needed.
         assign o_data = i_data;
      end else begin : g_store
         pixel_t r_sr [DEPTH];

         // Shift one stage per accepted pixel; contents are never cleared
         // because the fill counter upstream keeps stale data from being used.
         always_ff @(posedge clk) begin
            if (i_en) begin
               r_sr[0] <= i_data;
               for (int i = 1; i < DEPTH; i++) begin
                  r_sr[i] <= r_sr[i-1];
               end
            end
         end

         assign o_data = r_sr[DEPTH-1];
      end
   endgenerate

endmodule : img_line_delay
`default_nettype wire

// File: rtl/img_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : img_buffer
//  Description : Sliding FILT_WIDTH x FILT_WIDTH window over a raster pixel
//                stream. Window shift registers are chained through line
//                delays; the registered output window and its valid flag
//                update on the same edge that accepts each pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_buffer
   import img_buffer_pkg::*;
#(
   parameter int WIDTH      = 256,
   parameter int HIGHT      = 256,
   parameter int FILT_WIDTH = 3,
   parameter     IMGFILE    = "Lena.mem"
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      enable,
   input  logic [c_PIX_W-1:0]                        dataIn,
   output logic [FILT_WIDTH*FILT_WIDTH*c_PIX_W-1:0]  FilterBuffer,
   output logic                                      FilterFlag
);

   localparam int c_TAPS     = FILT_WIDTH * FILT_WIDTH;
   localparam int c_FILL     = calc_fill(WIDTH, FILT_WIDTH);
   localparam int c_CNT_W    = $clog2(c_FILL + 1);
   localparam int c_DL_DEPTH = WIDTH - FILT_WIDTH;

   localparam logic [c_CNT_W-1:0] c_FILL_CNT = c_FILL[c_CNT_W-1:0];

   // Elaboration-time sanity check of the parameter set. HIGHT and IMGFILE
   // carry no function; they are only checked for plausibility here.
   generate
      if (FILT_WIDTH < 3 || (FILT_WIDTH % 2) == 0 || FILT_WIDTH > WIDTH ||
          HIGHT < 1 || $bits(IMGFILE) == 0) begin : g_bad_params
         $error("img_buffer: illegal parameter combination");
      end
   endgenerate

   // Window element k = r*FILT_WIDTH + c; row FILT_WIDTH-1 is the newest line,
   // column FILT_WIDTH-1 the newest pixel within a row.
   pixel_t                        r_win     [c_TAPS];
   pixel_t                        w_shift   [c_TAPS];
   pixel_t                        w_row_in  [FILT_WIDTH];
   logic [c_TAPS*c_PIX_W-1:0]     w_shift_flat;

   logic [c_CNT_W-1:0]            r_cnt;
   logic [c_CNT_W-1:0]            w_cnt_nxt;
   logic                          w_accept;
   logic                          w_full;

   // Reset outranks enable: a pixel presented during reset is not accepted,
   // which also keeps the line delays aligned with the window rows.
   assign w_accept = rst & enable;

   // Counter saturates at FILL so the stream is treated as continuous.
   assign w_cnt_nxt = (r_cnt == c_FILL_CNT) ? r_cnt : r_cnt + c_CNT_W'(1);
   assign w_full    = (w_cnt_nxt == c_FILL_CNT);

   // The bottom row takes pixels straight from the input.
   assign w_row_in[FILT_WIDTH-1] = dataIn;

   // Each upper row is fed by the left-most pixel of the row below, delayed
   // so that vertically adjacent elements are exactly WIDTH pixels apart.
   generate
      for (genvar r = 0; r < FILT_WIDTH - 1; r++) begin : g_line
         img_line_delay #(
            .DEPTH (c_DL_DEPTH)
         ) u_line_delay (
            .clk    (clk),
            .i_en   (w_accept),
            .i_data (r_win[(r + 1) * FILT_WIDTH]),
            .o_data (w_row_in[r])
         );
      end
   endgenerate

   // Next-state window: every row shifts one place left, new pixel enters
   // on the right.
   generate
      for (genvar r = 0; r < FILT_WIDTH; r++) begin : g_row
         for (genvar c = 0; c < FILT_WIDTH; c++) begin : g_col
            if (c == FILT_WIDTH - 1) begin : g_edge
               assign w_shift[r*FILT_WIDTH + c] = w_row_in[r];
            end else begin : g_inner
               assign w_shift[r*FILT_WIDTH + c] = r_win[r*FILT_WIDTH + c + 1];
            end
            assign w_shift_flat[(r*FILT_WIDTH + c)*c_PIX_W +: c_PIX_W] =
               w_shift[r*FILT_WIDTH + c];
         end
      end
   endgenerate

   // Internal window shift registers advance only on accepted pixels; they
   // need no reset because the output only exposes them once fully refilled.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_win <= w_shift;
      end
   end

   // Fill counter plus registered output window and valid flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt        <= '0;
         FilterFlag   <= 1'b0;
         FilterBuffer <= '0;
      end else if (enable) begin
         r_cnt      <= w_cnt_nxt;
         FilterFlag <= w_full;
         if (w_full) begin
            FilterBuffer <= w_shift_flat;
         end
      end else begin
         FilterFlag <= 1'b0;
      end
   end

endmodule : img_buffer
`default_nettype wire

// File: tb/tb_img_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_buffer
//  Description : Self-checking bench for img_buffer (WIDTH=4, FILT_WIDTH=3).
//                A behavioural pixel-history model predicts each cycle's
//                flag and window; predictions are queued and popped when the
//                DUT output becomes visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_buffer;

   localparam int c_W    = 4;
   localparam int c_F    = 3;
   localparam int c_FILL = (c_F - 1) * c_W + c_F;
   localparam int c_BW   = c_F * c_F * 8;

   typedef struct packed {
      logic            flag;
      logic [c_BW-1:0] win;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [7:0]      dataIn;
   logic [c_BW-1:0] FilterBuffer;
   logic            FilterFlag;

   exp_t            exp_q [$];
   logic [7:0]      m_hist [$];
   int              m_cnt;
   logic [c_BW-1:0] m_buf;

   int n_cmp = 0;
   int n_err = 0;

   img_buffer #(
      .WIDTH      (c_W),
      .HIGHT      (4),
      .FILT_WIDTH (c_F),
      .IMGFILE    ("Lena.mem")
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .dataIn       (dataIn),
      .FilterBuffer (FilterBuffer),
      .FilterFlag   (FilterFlag)
   );

   always #5 clk = ~clk;

   // Drive one cycle, advance the model, queue the prediction, then wait
   // until just after the edge so outputs can be sampled.
   task automatic drive(input logic rn, input logic en, input logic [7:0] d);
      exp_t e;
      @(negedge clk);
      rst    = rn;
      enable = en;
      dataIn = d;
      e.flag = 1'b0;
      if (!rn) begin
         m_cnt = 0;
         m_buf = '0;
         m_hist.delete();
      end else if (en) begin
         m_hist.push_back(d);
         if (m_hist.size() > c_FILL) void'(m_hist.pop_front());
         if (m_cnt < c_FILL) m_cnt++;
         if (m_cnt == c_FILL) begin
            e.flag = 1'b1;
            for (int r = 0; r < c_F; r++)
               for (int c = 0; c < c_F; c++)
                  m_buf[(r*c_F + c)*8 +: 8] =
                     m_hist[m_hist.size() - 1 - ((c_F-1-r)*c_W + (c_F-1-c))];
         end
      end
      e.win = m_buf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [c_BW-1:0] pack9(input int b [9]);
      logic [c_BW-1:0] v;
      for (int k = 0; k < 9; k++) v[k*8 +: 8] = b[k][7:0];
      return v;
   endfunction

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 8'd55);
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== 1'b0 || FilterBuffer !== '0 || e.flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset: flag=%b buf=%h, want flag=0 buf=0", FilterFlag, FilterBuffer);
         end
      end
   endtask

   task automatic test_fill();
      exp_t e;
      int   b [9];
      for (int i = 0; i <= 10; i++) begin
         drive(1'b1, 1'b1, 8'(i));
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== e.flag || FilterBuffer !== e.win) begin
            n_err++;
            $display("FAIL fill[%0d]: flag=%b buf=%h, want flag=%b buf=%h",
                     i, FilterFlag, FilterBuffer, e.flag, e.win);
         end
      end
      b = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      n_cmp++;
      if (FilterFlag !== 1'b1 || FilterBuffer !== pack9(b)) begin
         n_err++;
         $display("FAIL first_window: flag=%b buf=%h, want flag=1 buf=%h",
                  FilterFlag, FilterBuffer, pack9(b));
      end
   endtask

   task automatic test_straddle();
      exp_t e;
      int   b [9];
      drive(1'b1, 1'b1, 8'd11);
      e = exp_q.pop_front();
      b = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      n_cmp++;
      if (FilterFlag !== e.flag || FilterBuffer !== e.win || FilterBuffer !== pack9(b)) begin
         n_err++;
         $display("FAIL straddle: flag=%b buf=%h, want flag=1 buf=%h",
                  FilterFlag, FilterBuffer, pack9(b));
      end
   endtask

   task automatic test_stall();
      exp_t e;
      int   b [9];
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'hEE);
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== 1'b0 || FilterBuffer !== e.win) begin
            n_err++;
            $display("FAIL stall[%0d]: flag=%b buf=%h, want flag=0 buf=%h",
                     i, FilterFlag, FilterBuffer, e.win);
         end
      end
      drive(1'b1, 1'b1, 8'd12);
      e = exp_q.pop_front();
      b = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
      n_cmp++;
      if (FilterFlag !== 1'b1 || FilterBuffer !== e.win || FilterBuffer !== pack9(b)) begin
         n_err++;
         $display("FAIL after_stall: flag=%b buf=%h, want flag=1 buf=%h",
                  FilterFlag, FilterBuffer, pack9(b));
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   b [9];
      drive(1'b0, 1'b1, 8'd99);
      e = exp_q.pop_front();
      n_cmp++;
      if (FilterFlag !== 1'b0 || FilterBuffer !== '0) begin
         n_err++;
         $display("FAIL mid_reset: flag=%b buf=%h, want flag=0 buf=0", FilterFlag, FilterBuffer);
      end
      for (int i = 100; i <= 110; i++) begin
         drive(1'b1, 1'b1, 8'(i));
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== e.flag || FilterBuffer !== e.win) begin
            n_err++;
            $display("FAIL refill[%0d]: flag=%b buf=%h, want flag=%b buf=%h",
                     i, FilterFlag, FilterBuffer, e.flag, e.win);
         end
      end
      b = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
      n_cmp++;
      if (FilterFlag !== 1'b1 || FilterBuffer !== pack9(b)) begin
         n_err++;
         $display("FAIL refill_window: flag=%b buf=%h, want flag=1 buf=%h",
                  FilterFlag, FilterBuffer, pack9(b));
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      drive(1'b0, 1'b0, 8'd0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b1, 8'($urandom_range(0, 255)));
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== e.flag || FilterBuffer !== e.win || FilterFlag !== (i >= c_FILL - 1)) begin
            n_err++;
            $display("FAIL stream[%0d]: flag=%b buf=%h, want flag=%b buf=%h",
                     i, FilterFlag, FilterBuffer, e.flag, e.win);
         end
      end
   endtask

   task automatic test_random_enable();
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         e = exp_q.pop_front();
         n_cmp++;
         if (FilterFlag !== e.flag || FilterBuffer !== e.win) begin
            n_err++;
            $display("FAIL rand_en[%0d]: flag=%b buf=%h, want flag=%b buf=%h",
                     i, FilterFlag, FilterBuffer, e.flag, e.win);
         end
      end
   endtask

   initial begin
      rst    = 1'b0;
      enable = 1'b0;
      dataIn = 8'd0;
      m_cnt  = 0;
      m_buf  = '0;
      test_reset();
      test_fill();
      test_straddle();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_img_buffer
`default_nettype wire
